// File: rtl/mul_man_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : mul_man_resolve
//  Purpose  : Consumer end of the mantissa multiplier. Resolves the Wallace-tree
//             carry-save pair with the final carry-propagate add. Normalises
//             the product, rounds it to nearest-even as a 12-bit mantissa and
//             reports the exponent adjustment. Two-stage valid/ready pipeline.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             in_valid/in_ready     - input handshake
//             in_sum[23:0]          - carry-save sum word
//             in_carry[18:0]        - carry-save carry word, weight 2^5
//             in_tag[TAG_W-1:0]     - sideband, passed through unchanged
//             out_valid/out_ready   - output handshake
//             out_man[11:0]         - rounded mantissa (bit 11 = leading one)
//             out_adj[1:0]          - exponent increment (0, 1 or 2)
//             out_inexact           - guard|sticky nonzero before rounding
//             out_zero              - resolved product is zero
//             out_unnorm            - nonzero product with bits 23:22 clear
//             out_tag[TAG_W-1:0]    - tag of this result
//  Revision : 1.0 - initial release
// ============================================================================
module mul_man_resolve #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_sum,
    input  logic [18:0]      in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_man,
    output logic [1:0]       out_adj,
    output logic             out_inexact,
    output logic             out_zero,
    output logic             out_unnorm,
    output logic [TAG_W-1:0] out_tag
);

    // ------------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------------
    logic             r_s1_valid;
    logic [23:0]      r_s1_sum;
    logic [18:0]      r_s1_carry;
    logic [TAG_W-1:0] r_s1_tag;

    logic w_s2_free;
    logic w_accept;
    logic w_advance;

    assign w_s2_free = !out_valid || out_ready;
    assign in_ready  = !rst && (!r_s1_valid || w_s2_free);
    assign w_accept  = in_valid && in_ready;
    assign w_advance = r_s1_valid && w_s2_free;

    // ------------------------------------------------------------------------
    // Stage 1: capture the carry-save pair
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_carry <= '0;
            r_s1_tag   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_sum   <= in_sum;
            r_s1_carry <= in_carry;
            r_s1_tag   <= in_tag;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 combinational: resolve, normalise, round
    // ------------------------------------------------------------------------
    // The carry word is aligned at bit 5, so the low five sum bits pass
    // straight through; any carry out of bit 23 is dropped.
    logic [18:0] w_hi;
    logic [23:0] w_prod;

    assign w_hi   = r_s1_sum[23:5] + r_s1_carry;
    assign w_prod = {w_hi, r_s1_sum[4:0]};

    logic [11:0] w_man;
    logic        w_g;
    logic        w_s;
    logic [1:0]  w_adj;
    logic        w_up;
    logic [12:0] w_rnd;
    logic [11:0] w_res_man;
    logic [1:0]  w_res_adj;
    logic        w_inexact;
    logic        w_zero;
    logic        w_unnorm;

    always_comb begin
        w_man     = w_prod[22:11];
        w_g       = w_prod[10];
        w_s       = |w_prod[9:0];
        w_adj     = 2'd0;
        w_up      = 1'b0;
        w_rnd     = '0;
        w_res_man = '0;
        w_res_adj = '0;
        w_inexact = 1'b0;
        w_zero    = (w_prod == 24'd0);
        w_unnorm  = !w_zero && !w_prod[23] && !w_prod[22];

        // Product in [2.0, 4.0): take one more bit off the bottom.
        if (w_prod[23]) begin
            w_man = w_prod[23:12];
            w_g   = w_prod[11];
            w_s   = |w_prod[10:0];
            w_adj = 2'd1;
        end

        // Round to nearest, ties to even.
        w_up  = w_g && (w_s || w_man[0]);
        w_rnd = {1'b0, w_man} + {12'd0, w_up};

        if (w_rnd[12]) begin
            // 0xFFF rounded up: renormalise to 1.000 and bump the exponent.
            w_res_man = 12'h800;
            w_res_adj = w_adj + 2'd1;
        end else begin
            w_res_man = w_rnd[11:0];
            w_res_adj = w_adj;
        end
        w_inexact = w_g || w_s;

        if (w_zero) begin
            w_res_man = '0;
            w_res_adj = '0;
            w_inexact = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_man     <= '0;
            out_adj     <= '0;
            out_inexact <= 1'b0;
            out_zero    <= 1'b0;
            out_unnorm  <= 1'b0;
            out_tag     <= '0;
        end else if (w_advance) begin
            out_valid   <= 1'b1;
            out_man     <= w_res_man;
            out_adj     <= w_res_adj;
            out_inexact <= w_inexact;
            out_zero    <= w_zero;
            out_unnorm  <= w_unnorm;
            out_tag     <= r_s1_tag;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_man_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_man_resolve
//  Purpose  : Self-checking bench for mul_man_resolve. Directed steps drive
//             the input side; a negedge monitor keeps a scoreboard of expected
//             results (from an independent arithmetic model) and checks
//             output order, values, stall stability and in_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_man_resolve;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_sum;
    logic [18:0]      in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [11:0]      out_man;
    logic [1:0]       out_adj;
    logic             out_inexact;
    logic             out_zero;
    logic             out_unnorm;
    logic [TAG_W-1:0] out_tag;

    mul_man_resolve #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_man    (out_man),
        .out_adj    (out_adj),
        .out_inexact(out_inexact),
        .out_zero   (out_zero),
        .out_unnorm (out_unnorm),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0]      man;
        logic [1:0]       adj;
        logic             inx;
        logic             zero;
        logic             unnorm;
        logic [TAG_W-1:0] tag;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   emitted = 0;
    res_t q[$];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Reference: full-width add, then explicit remainder-vs-half rounding.
    function automatic res_t model(input logic [23:0] s, input logic [18:0] c,
                                   input logic [TAG_W-1:0] t);
        res_t        r;
        logic [23:0] p;
        logic [12:0] m;
        logic [11:0] rem;
        logic [11:0] half;
        p = s + {c, 5'b0};
        r = '0;
        r.tag = t;
        if (p == 24'd0) begin
            r.zero = 1'b1;
            return r;
        end
        r.unnorm = (p[23:22] == 2'b00);
        if (p[23]) begin
            m    = {1'b0, p[23:12]};
            rem  = p[11:0];
            half = 12'h800;
            r.adj = 2'd1;
        end else begin
            m    = {1'b0, p[22:11]};
            rem  = {1'b0, p[10:0]};
            half = 12'h400;
            r.adj = 2'd0;
        end
        r.inx = (rem != 12'd0);
        if (rem > half || (rem == half && m[0])) m = m + 13'd1;
        if (m == 13'h1000) begin
            m = 13'h0800;
            r.adj = r.adj + 2'd1;
        end
        r.man = m[11:0];
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: at negedge the sampled handshakes are those of the next posedge
    // ------------------------------------------------------------------------
    logic                 prev_stall = 1'b0;
    logic [TAG_W+18:0]    prev_out;
    logic [TAG_W+18:0]    cur_out;
    logic                 exp_ir;
    res_t                 got;
    res_t                 want;

    always @(negedge clk) begin
        cur_out = {out_valid, out_man, out_adj, out_inexact, out_zero, out_unnorm, out_tag};
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            exp_ir = (q.size() <= (out_valid ? 1 : 0)) || !out_valid || out_ready;
            chk("in_ready_rule", in_ready, exp_ir);
            if (prev_stall) chk("stall_stable", cur_out, prev_out);
            if (out_valid && out_ready) begin
                got = '{out_man, out_adj, out_inexact, out_zero, out_unnorm, out_tag};
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    want = q.pop_front();
                    chk("result", got, want);
                end
                emitted++;
            end
            if (in_valid && in_ready) q.push_back(model(in_sum, in_carry, in_tag));
            prev_stall = out_valid && !out_ready;
        end
        prev_out = cur_out;
    end

    // Single transfer into an empty pipe; checks latency and literal results.
    task automatic send_check(input string nm, input logic [23:0] s, input logic [18:0] c,
                              input logic [TAG_W-1:0] t, input logic [11:0] em,
                              input logic [1:0] ea, input logic ei, input logic ez,
                              input logic eu);
        int n;
        in_sum = s; in_carry = c; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_man"}, out_man, em);
        chk({nm, "_adj"}, out_adj, ea);
        chk({nm, "_flags"}, {out_inexact, out_zero, out_unnorm}, {ei, ez, eu});
        chk({nm, "_tag"}, out_tag, t);
        @(posedge clk); #1;
    endtask

    logic [23:0] st_sum [8];
    logic [18:0] st_car [8];

    initial begin
        int idx;
        int cyc;
        int base;
        logic acc;

        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_tag = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk); #1;
        chk("reset_state", {out_valid, out_man, out_adj, out_inexact, out_zero,
                            out_unnorm, out_tag}, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        send_check("one_x_one", 24'h400000, 19'h0, 8'h11, 12'h800, 2'd0, 0, 0, 0);
        send_check("one5_sq", 24'h8FFFE0, 19'h1, 8'h22, 12'h900, 2'd1, 0, 0, 0);
        send_check("rne_ovf", 24'hFFF800, 19'h0, 8'h33, 12'h800, 2'd2, 1, 0, 0);
        send_check("tie_even", 24'h800800, 19'h0, 8'h44, 12'h800, 2'd1, 1, 0, 0);
        send_check("tie_odd", 24'h801800, 19'h0, 8'h55, 12'h802, 2'd1, 1, 0, 0);
        send_check("zero", 24'h000000, 19'h0, 8'h66, 12'h000, 2'd0, 0, 1, 0);
        send_check("zero_wrap", 24'hFFFFE0, 19'h1, 8'h67, 12'h000, 2'd0, 0, 1, 0);
        send_check("unnorm", 24'h000800, 19'h0, 8'h77, 12'h001, 2'd0, 0, 0, 1);

        // Streaming with out_ready toggling and in_valid held high.
        for (int i = 0; i < 8; i++) begin
            st_sum[i] = 24'h400000 + 24'h0123A5 * i[23:0];
            st_car[i] = 19'h00F31 * i[18:0];
        end
        base = emitted;
        idx = 0; cyc = 0;
        in_valid = 1'b1;
        while (idx < 8 && cyc < 100) begin
            in_sum = st_sum[idx]; in_carry = st_car[idx]; in_tag = idx[TAG_W-1:0];
            out_ready = (cyc % 2 == 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_all_sent", idx, 8);
        while ((q.size() > 0 || out_valid) && cyc < 200) begin
            out_ready = (cyc % 2 == 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream_emitted", emitted - base, 8);
        chk("stream_drained", q.size(), 0);

        // Reset with two products in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_sum = 24'h400000; in_carry = '0; in_tag = 8'hA0;
        @(posedge clk); #1;
        in_sum = 24'h500000; in_tag = 8'hA1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("both_full_in_ready", {out_valid, in_ready}, 2'b10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        base = emitted;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_nothing_emitted", {out_valid, 32'(emitted - base)}, 0);

        // Pipe still works after the flush.
        send_check("post_flush", 24'h600000, 19'h0, 8'hB0, 12'hC00, 2'd0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
